// File: rtl/mem_arbiter.sv
// Two-master memory arbiter in front of a single LSU port.
// One command is accepted in IDLE, performed in a single ACCESS cycle,
// and completed back to its master. Conflicts go round-robin, or to
// master 0 when P_FIXED_PRIO is set.
module mem_arbiter #(
  parameter int unsigned P_FIXED_PRIO = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // master 0 (core)
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m0_wren,
  input  logic [1:0]  i_m0_op,
  input  logic        i_m0_ld_un,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_err,
  // master 1 (loader)
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic        i_m1_wren,
  input  logic [1:0]  i_m1_op,
  input  logic        i_m1_ld_un,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_err,
  // LSU side
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic [1:0]  o_lsu_op,
  output logic        o_ld_un,
  input  logic [31:0] i_ld_data,
  output logic        o_busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  state_e      state_q, state_d;
  // Last granted master (1 = m1); also identifies the owner during ACCESS.
  logic        ptr_q, ptr_d;
  logic        acc_err_q, acc_err_d;
  logic [31:0] lsu_addr_q, lsu_addr_d;
  logic [31:0] st_data_q, st_data_d;
  logic        lsu_wren_q, lsu_wren_d;
  logic [1:0]  lsu_op_q, lsu_op_d;
  logic        ld_un_q, ld_un_d;
  logic        m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic        m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic        sel_m1;
  logic [31:0] win_addr, win_wdata;
  logic        win_wren, win_ld_un;
  logic [1:0]  win_op;
  logic        win_bad;
  logic [15:0] win_page;

  // Winner selection and command mux; also flags unmapped or read-only writes.
  always_comb begin
    sel_m1 = 1'b0;
    if (i_m0_req && i_m1_req) begin
      sel_m1 = (P_FIXED_PRIO != 0) ? 1'b0 : ~ptr_q;
    end else begin
      sel_m1 = i_m1_req;
    end
    win_addr  = sel_m1 ? i_m1_addr  : i_m0_addr;
    win_wdata = sel_m1 ? i_m1_wdata : i_m0_wdata;
    win_wren  = sel_m1 ? i_m1_wren  : i_m0_wren;
    win_op    = sel_m1 ? i_m1_op    : i_m0_op;
    win_ld_un = sel_m1 ? i_m1_ld_un : i_m0_ld_un;
    win_page  = win_addr[31:16];
    win_bad   = !((win_page == 16'h0000) || (win_page == 16'h1000) ||
                  (win_page == 16'h1001))
                || ((win_page == 16'h1001) && win_wren);
  end

  // Next-state and output logic; handshake pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    acc_err_d   = acc_err_q;
    lsu_addr_d  = lsu_addr_q;
    st_data_d   = st_data_q;
    lsu_wren_d  = 1'b0;
    lsu_op_d    = lsu_op_q;
    ld_un_d     = ld_un_q;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_m0_req || i_m1_req) begin
          lsu_addr_d = win_addr;
          st_data_d  = win_wdata;
          lsu_wren_d = win_wren && !win_bad;
          lsu_op_d   = win_op;
          ld_un_d    = win_ld_un;
          acc_err_d  = win_bad;
          ptr_d      = sel_m1;
          m0_gnt_d   = !sel_m1;
          m1_gnt_d   = sel_m1;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (ptr_q) begin
          m1_rvalid_d = 1'b1;
          m1_err_d    = acc_err_q;
          m1_rdata_d  = acc_err_q ? '0 : i_ld_data;
        end else begin
          m0_rvalid_d = 1'b1;
          m0_err_d    = acc_err_q;
          m0_rdata_d  = acc_err_q ? '0 : i_ld_data;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b1;
      acc_err_q   <= 1'b0;
      lsu_addr_q  <= '0;
      st_data_q   <= '0;
      lsu_wren_q  <= 1'b0;
      lsu_op_q    <= '0;
      ld_un_q     <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      acc_err_q   <= acc_err_d;
      lsu_addr_q  <= lsu_addr_d;
      st_data_q   <= st_data_d;
      lsu_wren_q  <= lsu_wren_d;
      lsu_op_q    <= lsu_op_d;
      ld_un_q     <= ld_un_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign o_m0_gnt    = m0_gnt_q;
  assign o_m0_rvalid = m0_rvalid_q;
  assign o_m0_rdata  = m0_rdata_q;
  assign o_m0_err    = m0_err_q;
  assign o_m1_gnt    = m1_gnt_q;
  assign o_m1_rvalid = m1_rvalid_q;
  assign o_m1_rdata  = m1_rdata_q;
  assign o_m1_err    = m1_err_q;
  assign o_lsu_addr  = lsu_addr_q;
  assign o_st_data   = st_data_q;
  assign o_lsu_wren  = lsu_wren_q;
  assign o_lsu_op    = lsu_op_q;
  assign o_ld_un     = ld_un_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance checked through a
// completion scoreboard, plus a fixed-priority instance on the same stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wren, m0_ld_un, m1_req, m1_wren, m1_ld_un;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_op, m1_op;

  // round-robin instance outputs
  logic        a_m0_gnt, a_m0_rvalid, a_m0_err, a_m1_gnt, a_m1_rvalid, a_m1_err;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_lsu_addr, a_st_data, a_ld_data;
  logic        a_lsu_wren, a_ld_un, a_busy;
  logic [1:0]  a_lsu_op;
  // fixed-priority instance outputs
  logic        f_m0_gnt, f_m0_rvalid, f_m0_err, f_m1_gnt, f_m1_rvalid, f_m1_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_lsu_addr, f_st_data, f_ld_data;
  logic        f_lsu_wren, f_ld_un, f_busy;
  logic [1:0]  f_lsu_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned m;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h1000_0200;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEADBEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  assign a_ld_data = mem_model(a_lsu_addr);
  assign f_ld_data = mem_model(f_lsu_addr);

  always #5 clk = ~clk;

  mem_arbiter #(.P_FIXED_PRIO(0)) u_rr (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m0_wren(m0_wren), .i_m0_op(m0_op), .i_m0_ld_un(m0_ld_un),
    .o_m0_gnt(a_m0_gnt), .o_m0_rvalid(a_m0_rvalid), .o_m0_rdata(a_m0_rdata),
    .o_m0_err(a_m0_err),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_wren(m1_wren), .i_m1_op(m1_op), .i_m1_ld_un(m1_ld_un),
    .o_m1_gnt(a_m1_gnt), .o_m1_rvalid(a_m1_rvalid), .o_m1_rdata(a_m1_rdata),
    .o_m1_err(a_m1_err),
    .o_lsu_addr(a_lsu_addr), .o_st_data(a_st_data), .o_lsu_wren(a_lsu_wren),
    .o_lsu_op(a_lsu_op), .o_ld_un(a_ld_un), .i_ld_data(a_ld_data),
    .o_busy(a_busy)
  );

  mem_arbiter #(.P_FIXED_PRIO(1)) u_fx (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m0_wren(m0_wren), .i_m0_op(m0_op), .i_m0_ld_un(m0_ld_un),
    .o_m0_gnt(f_m0_gnt), .o_m0_rvalid(f_m0_rvalid), .o_m0_rdata(f_m0_rdata),
    .o_m0_err(f_m0_err),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_wren(m1_wren), .i_m1_op(m1_op), .i_m1_ld_un(m1_ld_un),
    .o_m1_gnt(f_m1_gnt), .o_m1_rvalid(f_m1_rvalid), .o_m1_rdata(f_m1_rdata),
    .o_m1_err(f_m1_err),
    .o_lsu_addr(f_lsu_addr), .o_st_data(f_st_data), .o_lsu_wren(f_lsu_wren),
    .o_lsu_op(f_lsu_op), .o_ld_un(f_ld_un), .i_ld_data(f_ld_data),
    .o_busy(f_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor for the round-robin instance: every rvalid must
  // match the oldest expected completion.
  always @(negedge clk) begin
    if (rst === 1'b1 && (a_m0_rvalid || a_m1_rvalid)) begin
      check("rv_exclusive", 32'(a_m0_rvalid & a_m1_rvalid), 32'd0);
      if (sb.size() == 0) begin
        check("rv_unexpected", 32'(a_m0_rvalid | a_m1_rvalid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.m == 0) begin
          check("rv_m0_owner", 32'(a_m0_rvalid), 32'd1);
          check("rv_m0_err", 32'(a_m0_err), 32'(e.err));
          if (e.chk_data) check("rv_m0_rdata", a_m0_rdata, e.data);
          else check("rv_m0_rdata_known", 32'($isunknown(a_m0_rdata)), 32'd0);
        end else begin
          check("rv_m1_owner", 32'(a_m1_rvalid), 32'd1);
          check("rv_m1_err", 32'(a_m1_err), 32'(e.err));
          if (e.chk_data) check("rv_m1_rdata", a_m1_rdata, e.data);
          else check("rv_m1_rdata_known", 32'($isunknown(a_m1_rdata)), 32'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_wren = 0; m0_op = '0; m0_ld_un = 0;
    m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_wren = 0; m1_op = '0; m1_ld_un = 0;

    // reset state
    #12;
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_gnt", 32'({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid}), 32'd0);
    check("rst_wren", 32'(a_lsu_wren), 32'd0);
    check("rst_lsu_addr", a_lsu_addr, 32'd0);
    check("rst_m0_rdata", a_m0_rdata, 32'd0);
    #1 rst = 1'b1;
    cyc();

    // single read by m0
    m0_req = 1; m0_addr = 32'h0000_0010; m0_wren = 0; m0_op = 2'b00; m0_ld_un = 0;
    sb.push_back('{0, 32'hDEADBEEF, 1'b0, 1'b1});
    cyc();
    check("rd_m0_gnt", 32'(a_m0_gnt), 32'd1);
    check("rd_m1_gnt", 32'(a_m1_gnt), 32'd0);
    check("rd_busy", 32'(a_busy), 32'd1);
    check("rd_lsu_addr", a_lsu_addr, 32'h0000_0010);
    check("rd_wren", 32'(a_lsu_wren), 32'd0);
    m0_req = 0;
    cyc();
    check("rd_gnt_pulse", 32'(a_m0_gnt), 32'd0);
    check("rd_rvalid", 32'(a_m0_rvalid), 32'd1);
    check("rd_busy_done", 32'(a_busy), 32'd0);
    cyc();
    check("rd_rvalid_pulse", 32'(a_m0_rvalid), 32'd0);
    check("rd_rdata_hold", a_m0_rdata, 32'hDEADBEEF);

    // word write by m1
    m1_req = 1; m1_addr = 32'h1000_0000; m1_wdata = 32'h1234_5678; m1_wren = 1;
    m1_op = 2'b00;
    sb.push_back('{1, 32'h0, 1'b0, 1'b0});
    cyc();
    check("wr_m1_gnt", 32'(a_m1_gnt), 32'd1);
    check("wr_wren", 32'(a_lsu_wren), 32'd1);
    check("wr_lsu_addr", a_lsu_addr, 32'h1000_0000);
    check("wr_st_data", a_st_data, 32'h1234_5678);
    m1_req = 0; m1_wren = 0;
    cyc();
    check("wr_wren_end", 32'(a_lsu_wren), 32'd0);
    check("wr_m1_rvalid", 32'(a_m1_rvalid), 32'd1);
    check("wr_m0_rdata_hold", a_m0_rdata, 32'hDEADBEEF);
    cyc();
    check("wr_wren_idle", 32'(a_lsu_wren), 32'd0);

    // write to read-only page, then read of an unmapped page
    m0_req = 1; m0_addr = 32'h1001_0000; m0_wdata = 32'hCAFE_F00D; m0_wren = 1;
    sb.push_back('{0, 32'h0, 1'b1, 1'b1});
    cyc();
    check("ro_gnt", 32'(a_m0_gnt), 32'd1);
    check("ro_wren", 32'(a_lsu_wren), 32'd0);
    m0_addr = 32'h2000_0000; m0_wren = 0;
    sb.push_back('{0, 32'h0, 1'b1, 1'b1});
    cyc();
    check("ro_err", 32'(a_m0_err), 32'd1);
    cyc();
    check("um_gnt", 32'(a_m0_gnt), 32'd1);
    check("um_wren", 32'(a_lsu_wren), 32'd0);
    m0_req = 0;
    cyc();
    check("um_err", 32'(a_m0_err), 32'd1);
    check("um_rdata", a_m0_rdata, 32'd0);
    cyc();

    // reset during the access cycle of a write
    m1_req = 1; m1_addr = 32'h1000_0004; m1_wdata = 32'hA5A5_0001; m1_wren = 1;
    cyc();
    check("ab_gnt", 32'(a_m1_gnt), 32'd1);
    check("ab_wren_before", 32'(a_lsu_wren), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("ab_wren_drop", 32'(a_lsu_wren), 32'd0);
    check("ab_busy_drop", 32'(a_busy), 32'd0);
    check("ab_m1_rdata_clr", a_m1_rdata, 32'd0);
    m1_req = 0; m1_wren = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    cyc();
    check("ab_no_rvalid", 32'(a_m1_rvalid), 32'd0);

    // both masters request continuously
    m0_req = 1; m0_addr = A0; m0_wren = 0; m0_op = 2'b00; m0_ld_un = 0;
    m1_req = 1; m1_addr = A1; m1_wren = 0; m1_op = 2'b11; m1_ld_un = 1;
    sb.push_back('{0, mem_model(A0), 1'b0, 1'b1});
    sb.push_back('{1, mem_model(A1), 1'b0, 1'b1});
    sb.push_back('{0, mem_model(A0), 1'b0, 1'b1});
    sb.push_back('{1, mem_model(A1), 1'b0, 1'b1});
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("rr_m0_gnt", 32'(a_m0_gnt), 32'(k % 2 == 0));
      check("rr_m1_gnt", 32'(a_m1_gnt), 32'(k % 2 == 1));
      check("rr_lsu_addr", a_lsu_addr, (k % 2 == 1) ? A1 : A0);
      check("rr_lsu_op", 32'(a_lsu_op), (k % 2 == 1) ? 32'd3 : 32'd0);
      check("rr_ld_un", 32'(a_ld_un), 32'(k % 2 == 1));
      check("fx_m0_gnt", 32'(f_m0_gnt), 32'd1);
      check("fx_m1_gnt", 32'(f_m1_gnt), 32'd0);
      if (k == 3) begin
        m0_req = 0;
        m1_req = 0;
      end
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("idle_fx_m1_gnt", 32'(f_m1_gnt), 32'd0);
      check("idle_rr_busy", 32'(a_busy), 32'd0);
    end
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
